// File: rtl/bnn_argmax_ctrl_if.sv
// Handshake bundle for bnn_argmax_ctrl: popcount snapshot input and the
// one-beat class-index AXI-stream output. master = the controller side.
interface bnn_argmax_ctrl_if #(
  parameter int NUM_CLASSES      = 10,
  parameter int COUNT_WIDTH      = 32,
  parameter int OUTPUT_BUS_WIDTH = 8
);
  logic [COUNT_WIDTH-1:0]        count_in [NUM_CLASSES];
  logic                          count_valid;
  logic                          count_ready;
  logic                          data_out_valid;
  logic                          data_out_ready;
  logic [OUTPUT_BUS_WIDTH-1:0]   data_out_data;
  logic [OUTPUT_BUS_WIDTH/8-1:0] data_out_keep;
  logic                          data_out_last;

  modport master (
    input  count_in, count_valid, data_out_ready,
    output count_ready, data_out_valid, data_out_data, data_out_keep, data_out_last
  );

  modport slave (
    output count_in, count_valid, data_out_ready,
    input  count_ready, data_out_valid, data_out_data, data_out_keep, data_out_last
  );
endinterface

// File: rtl/bnn_argmax_ctrl.sv
// Sequential argmax over a captured popcount snapshot, result emitted as a one-beat stream packet.
// Define BNN_ARGMAX_DUAL_COMPARE_EN to scan two entries per SCAN cycle.
//
// state | meaning
// IDLE  | ready for a new count vector (count_ready=1)
// SCAN  | walking the snapshot with the shared comparator
// OUT   | holding the winning class index on the output stream
module bnn_argmax_ctrl #(
  parameter int NUM_CLASSES       = 10,
  parameter int COUNT_WIDTH       = 32,
  parameter int OUTPUT_DATA_WIDTH = 4,
  parameter int OUTPUT_BUS_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  bnn_argmax_ctrl_if.master  io,
  output logic               busy
);
  localparam int IDX_W = $clog2(NUM_CLASSES + 1);
`ifdef BNN_ARGMAX_DUAL_COMPARE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  if (NUM_CLASSES < 1) begin : g_chk_nc
    $fatal(1, "bnn_argmax_ctrl: NUM_CLASSES must be >= 1");
  end
  if (OUTPUT_DATA_WIDTH < 1 || OUTPUT_DATA_WIDTH < $clog2(NUM_CLASSES)) begin : g_chk_odw
    $fatal(1, "bnn_argmax_ctrl: OUTPUT_DATA_WIDTH too small for NUM_CLASSES");
  end
  if ((OUTPUT_BUS_WIDTH % 8) != 0 || OUTPUT_BUS_WIDTH < OUTPUT_DATA_WIDTH) begin : g_chk_obw
    $fatal(1, "bnn_argmax_ctrl: OUTPUT_BUS_WIDTH must be a multiple of 8 and >= OUTPUT_DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;
  state_t state, state_nxt;

  logic [COUNT_WIDTH-1:0]       snap [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0]       best_val;
  logic [OUTPUT_DATA_WIDTH-1:0] best_idx;
  logic [IDX_W-1:0]             scan_idx;

  logic                         accept;
  logic                         scan_last;
  logic [COUNT_WIDTH-1:0]       cand_val;
  logic [OUTPUT_DATA_WIDTH-1:0] cand_idx;
`ifdef BNN_ARGMAX_DUAL_COMPARE_EN
  logic [COUNT_WIDTH-1:0]       lo_val;
  logic [COUNT_WIDTH-1:0]       hi_val;
  logic                         hi_ok;
`endif

  assign accept = (state == IDLE) && io.count_valid;

  // Candidate for this SCAN cycle; index select is a mux so scan_idx can run one past the end.
  always_comb begin
    cand_val = '0;
    cand_idx = '0;
`ifdef BNN_ARGMAX_DUAL_COMPARE_EN
    lo_val = '0;
    hi_val = '0;
    hi_ok  = 1'b0;
    for (int j = 0; j < NUM_CLASSES; j++) begin
      if (IDX_W'(j) == scan_idx) lo_val = snap[j];
      if (IDX_W'(j) == scan_idx + IDX_W'(1)) begin
        hi_val = snap[j];
        hi_ok  = 1'b1;
      end
    end
    if (hi_ok && (hi_val > lo_val)) begin
      cand_val = hi_val;
      cand_idx = OUTPUT_DATA_WIDTH'(scan_idx + IDX_W'(1));
    end else begin
      cand_val = lo_val;
      cand_idx = OUTPUT_DATA_WIDTH'(scan_idx);
    end
    scan_last = (int'(scan_idx) >= NUM_CLASSES - 2);
`else
    for (int j = 0; j < NUM_CLASSES; j++) begin
      if (IDX_W'(j) == scan_idx) cand_val = snap[j];
    end
    cand_idx  = OUTPUT_DATA_WIDTH'(scan_idx);
    scan_last = (int'(scan_idx) >= NUM_CLASSES - 1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (NUM_CLASSES == 1) ? OUT : SCAN;
      SCAN: if (scan_last) state_nxt = OUT;
      OUT:  if (io.data_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.count_ready    = (state == IDLE);
    io.data_out_valid = (state == OUT);
    io.data_out_last  = (state == OUT);
    io.data_out_keep  = (state == OUT) ? '1 : '0;
    io.data_out_data  = (state == OUT) ? OUTPUT_BUS_WIDTH'(best_idx) : '0;
    busy              = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int j = 0; j < NUM_CLASSES; j++) snap[j] <= io.count_in[j];
    end
  end

  // Strict greater-than keeps the earlier index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
      scan_idx <= '0;
    end else if (accept) begin
      best_val <= io.count_in[0];
      best_idx <= '0;
      scan_idx <= IDX_W'(1);
    end else if (state == SCAN) begin
      if (cand_val > best_val) begin
        best_val <= cand_val;
        best_idx <= cand_idx;
      end
      scan_idx <= scan_idx + IDX_W'(STEP);
    end
  end
endmodule

// File: tb/tb_bnn_argmax_ctrl.sv
// Randomized bench for bnn_argmax_ctrl against a first-index-of-maximum reference model,
// plus a NUM_CLASSES=1 instance. Honours BNN_ARGMAX_DUAL_COMPARE_EN for latency expectations.
module tb_bnn_argmax_ctrl;
  localparam int NC  = 10;
  localparam int CW  = 32;
  localparam int ODW = 4;
  localparam int OBW = 8;
`ifdef BNN_ARGMAX_DUAL_COMPARE_EN
  localparam int LAT = 1 + (NC - 1 + 1) / 2;
`else
  localparam int LAT = NC;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, busy1;
  always #5 clk = ~clk;

  bnn_argmax_ctrl_if #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW), .OUTPUT_BUS_WIDTH(OBW)) bus ();
  bnn_argmax_ctrl_if #(.NUM_CLASSES(1),  .COUNT_WIDTH(CW), .OUTPUT_BUS_WIDTH(OBW)) bus1 ();

  bnn_argmax_ctrl #(.NUM_CLASSES(NC), .COUNT_WIDTH(CW), .OUTPUT_DATA_WIDTH(ODW),
                    .OUTPUT_BUS_WIDTH(OBW))
    u_dut (.clk(clk), .rst(rst), .io(bus.master), .busy(busy));

  bnn_argmax_ctrl #(.NUM_CLASSES(1), .COUNT_WIDTH(CW), .OUTPUT_DATA_WIDTH(1),
                    .OUTPUT_BUS_WIDTH(OBW))
    u_dut1 (.clk(clk), .rst(rst), .io(bus1.master), .busy(busy1));

  int vectors = 0;
  int miscompares = 0;

  typedef logic [CW-1:0] vec_t [NC];

  function automatic int ref_argmax(input vec_t v);
    logic [CW-1:0] mx;
    mx = v[0];
    foreach (v[i]) if (v[i] > mx) mx = v[i];
    foreach (v[i]) if (v[i] == mx) return i;
    return 0;
  endfunction

  function automatic vec_t rand_vec(input bit narrow);
    vec_t v;
    foreach (v[i]) v[i] = narrow ? CW'($urandom_range(0, 7)) : CW'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    foreach (v[i]) bus.count_in[i] = v[i];
  endtask

  // Accept one vector from IDLE, then count edges after the accept edge until valid.
  task automatic accept_and_wait(input vec_t v, output int edges);
    drive(v);
    bus.count_valid = 1'b1;
    step();
    bus.count_valid = 1'b0;
    edges = 0;
    while (!bus.data_out_valid && edges < LAT + 5) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.count_valid = 1'b1;
    bus1.count_valid = 1'b1;
    drive(rand_vec(0));
    repeat (3) step();
    vectors++; if (bus.data_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.data_out_valid); end
    vectors++; if (bus.data_out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", bus.data_out_data); end
    vectors++; if (bus.data_out_keep !== 1'b0) begin miscompares++; $display("FAIL reset_keep: got %b want 0", bus.data_out_keep); end
    vectors++; if (bus.data_out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", bus.data_out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (bus.count_ready !== 1'b1) begin miscompares++; $display("FAIL reset_count_ready: got %b want 1", bus.count_ready); end
    vectors++; if (busy1 !== 1'b0 || bus1.data_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_nc1: busy=%b valid=%b want 0 0", busy1, bus1.data_out_valid); end
    bus.count_valid = 1'b0;
    bus1.count_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    vec_t pats [3];
    int edges, exp;
    pats[0] = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd0, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    foreach (pats[1][i]) pats[1][i] = (i == NC - 1) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    foreach (pats[2][i]) pats[2][i] = 32'h0000_1234;
    bus.data_out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp = (p == 0) ? 1 : (p == 1) ? NC - 1 : 0;
      accept_and_wait(pats[p], edges);
      vectors++; if (edges !== LAT - 1) begin miscompares++; $display("FAIL dir%0d_latency: got %0d edges want %0d", p, edges, LAT - 1); end
      vectors++; if (bus.data_out_data !== OBW'(exp)) begin miscompares++; $display("FAIL dir%0d_data: got %h want %h", p, bus.data_out_data, OBW'(exp)); end
      vectors++; if (bus.data_out_keep !== 1'b1 || bus.data_out_last !== 1'b1) begin miscompares++; $display("FAIL dir%0d_keep_last: got %b %b want 1 1", p, bus.data_out_keep, bus.data_out_last); end
      vectors++; if (bus.count_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL dir%0d_out_state: count_ready=%b busy=%b want 0 1", p, bus.count_ready, busy); end
      step();
      vectors++; if (bus.data_out_valid !== 1'b0 || bus.count_ready !== 1'b1) begin miscompares++; $display("FAIL dir%0d_return_idle: valid=%b count_ready=%b want 0 1", p, bus.data_out_valid, bus.count_ready); end
    end
    bus.data_out_ready = 1'b0;
  endtask

  task automatic test_random();
    vec_t v;
    int edges, exp, stall;
    logic [OBW-1:0] held;
    for (int n = 0; n < 30; n++) begin
      v = rand_vec(n[0]);
      exp = ref_argmax(v);
      stall = $urandom_range(0, 3);
      bus.data_out_ready = 1'b0;
      accept_and_wait(v, edges);
      drive(rand_vec(0));
      vectors++; if (edges !== LAT - 1) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d edges want %0d", n, edges, LAT - 1); end
      vectors++; if (bus.data_out_data !== OBW'(exp)) begin miscompares++; $display("FAIL rnd%0d_data: got %h want %h", n, bus.data_out_data, OBW'(exp)); end
      held = bus.data_out_data;
      for (int s = 0; s < stall; s++) step();
      vectors++; if (bus.data_out_valid !== 1'b1 || bus.data_out_data !== OBW'(exp)) begin miscompares++; $display("FAIL rnd%0d_stall: valid=%b data=%h want 1 %h", n, bus.data_out_valid, bus.data_out_data, OBW'(exp)); end
      bus.data_out_ready = 1'b1;
      step();
      bus.data_out_ready = 1'b0;
      vectors++; if (bus.data_out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_drop: valid=%b want 0 (held %h)", n, bus.data_out_valid, held); end
    end
  endtask

  task automatic test_backpressure();
    vec_t v, nv;
    int edges, exp, nexp;
    v = rand_vec(0);
    exp = ref_argmax(v);
    bus.data_out_ready = 1'b0;
    accept_and_wait(v, edges);
    vectors++; if (bus.data_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_rise: got %b want 1", bus.data_out_valid); end
    for (int c = 0; c < 20; c++) begin
      drive(rand_vec(c[0]));
      bus.count_valid = c[1];
      step();
      vectors++; if (bus.data_out_valid !== 1'b1 || bus.data_out_data !== OBW'(exp)) begin miscompares++; $display("FAIL bp_hold%0d: valid=%b data=%h want 1 %h", c, bus.data_out_valid, bus.data_out_data, OBW'(exp)); end
      vectors++; if (bus.count_ready !== 1'b0) begin miscompares++; $display("FAIL bp_count_ready%0d: got %b want 0", c, bus.count_ready); end
    end
    nv = rand_vec(1);
    nexp = ref_argmax(nv);
    drive(nv);
    bus.count_valid = 1'b1;
    bus.data_out_ready = 1'b1;
    step();
    bus.data_out_ready = 1'b0;
    vectors++; if (bus.data_out_valid !== 1'b0 || bus.count_ready !== 1'b1) begin miscompares++; $display("FAIL bp_handshake: valid=%b count_ready=%b want 0 1", bus.data_out_valid, bus.count_ready); end
    step();
    bus.count_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || bus.count_ready !== 1'b0) begin miscompares++; $display("FAIL bp_next_accept: busy=%b count_ready=%b want 1 0", busy, bus.count_ready); end
    edges = 0;
    while (!bus.data_out_valid && edges < LAT + 5) begin
      step();
      edges++;
    end
    vectors++; if (edges !== LAT - 1 || bus.data_out_data !== OBW'(nexp)) begin miscompares++; $display("FAIL bp_next_result: edges=%0d data=%h want %0d %h", edges, bus.data_out_data, LAT - 1, OBW'(nexp)); end
    bus.data_out_ready = 1'b1;
    step();
    bus.data_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t cur;
    int exp_q[$];
    int prev, naccept, nbeats, got_exp;
    logic acc, beat;
    logic [OBW-1:0] bdata;
    prev = -1; naccept = 0; nbeats = 0;
    cur = rand_vec(0);
    drive(cur);
    bus.count_valid = 1'b1;
    bus.data_out_ready = 1'b1;
    for (int cyc = 0; cyc < (LAT + 1) * 6 + 20 && nbeats < 4; cyc++) begin
      acc = bus.count_ready && bus.count_valid;
      beat = bus.data_out_valid && bus.data_out_ready;
      bdata = bus.data_out_data;
      step();
      if (acc) begin
        exp_q.push_back(ref_argmax(cur));
        if (prev >= 0) begin
          vectors++; if (cyc - prev !== LAT + 1) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", naccept, cyc - prev, LAT + 1); end
        end
        prev = cyc;
        naccept++;
        cur = rand_vec(naccept[0]);
        drive(cur);
        if (naccept == 4) bus.count_valid = 1'b0;
      end
      if (beat) begin
        got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        vectors++; if (got_exp < 0 || bdata !== OBW'(got_exp)) begin miscompares++; $display("FAIL b2b_beat%0d: got %h want %0d", nbeats, bdata, got_exp); end
        nbeats++;
      end
    end
    vectors++; if (nbeats !== 4) begin miscompares++; $display("FAIL b2b_beat_count: got %0d want 4", nbeats); end
    bus.count_valid = 1'b0;
    bus.data_out_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    int edges, seen;
    for (int mode = 0; mode < 2; mode++) begin
      bus.data_out_ready = 1'b0;
      drive(rand_vec(0));
      bus.count_valid = 1'b1;
      step();
      bus.count_valid = 1'b0;
      if (mode == 0) begin
        step();
        vectors++; if (busy !== 1'b1 || bus.data_out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_scan_pre: busy=%b valid=%b want 1 0", busy, bus.data_out_valid); end
      end else begin
        edges = 0;
        while (!bus.data_out_valid && edges < LAT + 5) begin
          step();
          edges++;
        end
        vectors++; if (bus.data_out_valid !== 1'b1) begin miscompares++; $display("FAIL abort_out_pre: valid=%b want 1", bus.data_out_valid); end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++; if (bus.data_out_valid !== 1'b0 || busy !== 1'b0 || bus.count_ready !== 1'b1) begin miscompares++; $display("FAIL abort%0d_state: valid=%b busy=%b count_ready=%b want 0 0 1", mode, bus.data_out_valid, busy, bus.count_ready); end
      bus.data_out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < LAT + 4; c++) begin
        step();
        if (bus.data_out_valid) seen++;
      end
      bus.data_out_ready = 1'b0;
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort%0d_no_beat: saw valid in %0d cycles want 0", mode, seen); end
    end
  endtask

  task automatic test_single_class();
    for (int n = 0; n < 3; n++) begin
      vectors++; if (bus1.count_ready !== 1'b1) begin miscompares++; $display("FAIL nc1_%0d_ready: got %b want 1", n, bus1.count_ready); end
      bus1.count_in[0] = CW'($urandom);
      bus1.data_out_ready = 1'b0;
      bus1.count_valid = 1'b1;
      step();
      bus1.count_valid = 1'b0;
      vectors++; if (bus1.data_out_valid !== 1'b1 || bus1.data_out_data !== 8'h00) begin miscompares++; $display("FAIL nc1_%0d_result: valid=%b data=%h want 1 00", n, bus1.data_out_valid, bus1.data_out_data); end
      vectors++; if (bus1.data_out_keep !== 1'b1 || bus1.data_out_last !== 1'b1 || bus1.count_ready !== 1'b0) begin miscompares++; $display("FAIL nc1_%0d_flags: keep=%b last=%b count_ready=%b want 1 1 0", n, bus1.data_out_keep, bus1.data_out_last, bus1.count_ready); end
      bus1.data_out_ready = 1'b1;
      step();
      bus1.data_out_ready = 1'b0;
      vectors++; if (bus1.data_out_valid !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL nc1_%0d_idle: valid=%b busy=%b want 0 0", n, bus1.data_out_valid, busy1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.count_valid = 1'b0;
    bus.data_out_ready = 1'b0;
    bus1.count_valid = 1'b0;
    bus1.data_out_ready = 1'b0;
    bus1.count_in[0] = '0;
    drive(rand_vec(0));
    step();
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_single_class();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
